// File: rtl/nco_mc_pkg.sv
// Shared types and constants for the multi-channel quarter-wave NCO.
// LFSR constants exist only when NCO_PHASE_DITHER_EN is defined.
package nco_mc_pkg;

    localparam int unsigned LAT = 3;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

`ifdef NCO_PHASE_DITHER_EN
    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
`endif

    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic int unsigned rom_entries(input int unsigned raw);
        return 32'd1 << raw;
    endfunction

    // round(amp * sin(pi/2 * (k+0.5) / 2^raw)) via a Q30 Taylor series
    function automatic longint rom_entry(input longint k, input int unsigned raw,
                                         input int unsigned mpr);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint amp;
        x    = (PI_Q30 * (2 * k + 1)) >>> (raw + 2);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (longint n = 1; n <= 12; n++) begin
            term = -(((term * x2) >>> 30) / ((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        amp = (64'sd1 <<< (mpr - 1)) - 64'sd1;
        return (acc * amp + (64'sd1 <<< 29)) >>> 30;
    endfunction

endpackage

// File: rtl/nco_qw_lut.sv
// Dual-read quarter-wave sine ROM: mirror/read registered, then negate registered.
module nco_qw_lut
    import nco_mc_pkg::*;
#(
    parameter int unsigned RAW = 8,
    parameter int unsigned MPR = 14
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           i_clken,
    input  quad_e          i_sin_quad,
    input  logic [RAW-1:0] i_sin_idx,
    input  quad_e          i_cos_quad,
    input  logic [RAW-1:0] i_cos_idx,
    output logic [MPR-1:0] o_sin,
    output logic [MPR-1:0] o_cos
);

    localparam int unsigned ROM_N = rom_entries(RAW);
    localparam int unsigned MW    = MPR - 1;

    logic [MW-1:0] w_rom [ROM_N];

    for (genvar k = 0; k < ROM_N; k++) begin : g_rom
        localparam longint ENTRY = rom_entry(longint'(k), RAW, MPR);
        assign w_rom[k] = MW'(ENTRY);
    end

    logic           w_sin_mirror;
    logic           w_cos_mirror;
    logic           w_sin_neg;
    logic           w_cos_neg;
    logic [RAW-1:0] w_sin_addr;
    logic [RAW-1:0] w_cos_addr;

    assign w_sin_mirror = (i_sin_quad == QUAD_1) || (i_sin_quad == QUAD_3);
    assign w_cos_mirror = (i_cos_quad == QUAD_1) || (i_cos_quad == QUAD_3);
    assign w_sin_neg    = (i_sin_quad == QUAD_2) || (i_sin_quad == QUAD_3);
    assign w_cos_neg    = (i_cos_quad == QUAD_2) || (i_cos_quad == QUAD_3);
    assign w_sin_addr   = w_sin_mirror ? ~i_sin_idx : i_sin_idx;
    assign w_cos_addr   = w_cos_mirror ? ~i_cos_idx : i_cos_idx;

    logic [MW-1:0]  r_sin_mag;
    logic [MW-1:0]  r_cos_mag;
    logic           r_sin_neg;
    logic           r_cos_neg;
    logic [MPR-1:0] r_sin;
    logic [MPR-1:0] r_cos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sin_mag <= '0;
            r_cos_mag <= '0;
            r_sin_neg <= 1'b0;
            r_cos_neg <= 1'b0;
            r_sin     <= '0;
            r_cos     <= '0;
        end else if (i_clken) begin
            r_sin_mag <= w_rom[w_sin_addr];
            r_cos_mag <= w_rom[w_cos_addr];
            r_sin_neg <= w_sin_neg;
            r_cos_neg <= w_cos_neg;
            r_sin     <= r_sin_neg ? -{1'b0, r_sin_mag} : {1'b0, r_sin_mag};
            r_cos     <= r_cos_neg ? -{1'b0, r_cos_mag} : {1'b0, r_cos_mag};
        end
    end

    assign o_sin = r_sin;
    assign o_cos = r_cos;

endmodule

// File: rtl/nco_mc_qw.sv
// Time-multiplexed multi-channel NCO with per-channel increment/offset and phase sync.
// Optional phase dither below the ROM truncation point: define NCO_PHASE_DITHER_EN.
module nco_mc_qw
    import nco_mc_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    parameter  int unsigned APR = 32,
    parameter  int unsigned RAW = 8,
    parameter  int unsigned MPR = 14,
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           clken,
    input  logic           cfg_wr,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [APR-1:0] cfg_inc,
    input  logic [APR-1:0] cfg_off,
    input  logic           sync_i,
    output logic [MPR-1:0] fsin_o,
    output logic [MPR-1:0] fcos_o,
    output logic [CHW-1:0] out_ch,
    output logic           out_valid
);

    localparam int unsigned PW   = RAW + 2;
    localparam int unsigned CHW1 = CHW + 1;

    logic [APR-1:0] r_acc [NCH];
    logic [APR-1:0] r_inc [NCH];
    logic [APR-1:0] r_off [NCH];
    logic [CHW-1:0] r_ch_cnt;
    logic [PW-1:0]  r_phase;
    logic [LAT-1:0] r_vld;
    logic [CHW-1:0] r_ch_pipe [LAT];
    logic           w_cfg_hit;
    logic [PW-1:0]  w_phase;

    assign w_cfg_hit = cfg_wr && ({1'b0, cfg_ch} < CHW1'(NCH));

    // Config port is independent of clken
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_inc[i] <= '0;
                r_off[i] <= '0;
            end
        end else if (w_cfg_hit) begin
            r_inc[cfg_ch] <= cfg_inc;
            r_off[cfg_ch] <= cfg_off;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
        end else if (clken) begin
            if (sync_i) begin
                for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
            end else begin
                r_acc[r_ch_cnt] <= r_acc[r_ch_cnt] + r_inc[r_ch_cnt];
            end
        end
    end

`ifdef NCO_PHASE_DITHER_EN
    localparam int unsigned DW = ((APR - PW) > 16) ? 16 : (APR - PW);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_lfsr_fb;

    assign w_lfsr_fb = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (reset)      r_lfsr <= LFSR_SEED;
        else if (clken) r_lfsr <= {r_lfsr[LFSR_W-2:0], w_lfsr_fb};
    end

    assign w_phase = PW'((r_acc[r_ch_cnt] + r_off[r_ch_cnt] + APR'(r_lfsr[DW-1:0])) >> (APR - PW));
`else
    // Only the top RAW+2 phase bits reach the ROM
    assign w_phase = PW'((r_acc[r_ch_cnt] + r_off[r_ch_cnt]) >> (APR - PW));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch_cnt <= '0;
            r_phase  <= '0;
            r_vld    <= '0;
            for (int i = 0; i < LAT; i++) r_ch_pipe[i] <= '0;
        end else if (clken) begin
            r_ch_cnt     <= (r_ch_cnt == CHW'(NCH - 1)) ? '0 : r_ch_cnt + CHW'(1);
            r_phase      <= w_phase;
            r_vld        <= {r_vld[LAT-2:0], 1'b1};
            r_ch_pipe[0] <= r_ch_cnt;
            for (int i = 1; i < LAT; i++) r_ch_pipe[i] <= r_ch_pipe[i-1];
        end
    end

    quad_e          w_sin_quad;
    quad_e          w_cos_quad;
    logic [RAW-1:0] w_idx;

    assign w_sin_quad = quad_e'(r_phase[PW-1 -: 2]);
    assign w_cos_quad = quad_e'(r_phase[PW-1 -: 2] + 2'd1);
    assign w_idx      = r_phase[RAW-1:0];

    nco_qw_lut #(
        .RAW (RAW),
        .MPR (MPR)
    ) u_lut (
        .clk        (clk),
        .reset      (reset),
        .i_clken    (clken),
        .i_sin_quad (w_sin_quad),
        .i_sin_idx  (w_idx),
        .i_cos_quad (w_cos_quad),
        .i_cos_idx  (w_idx),
        .o_sin      (fsin_o),
        .o_cos      (fcos_o)
    );

    assign out_valid = r_vld[LAT-1];
    assign out_ch    = r_ch_pipe[LAT-1];

endmodule
